// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : RV32I instruction-fetch stage. Owns the PC and keeps at most
//               one request outstanding on the req/gnt/rvalid memory port.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        RedirectE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_instr;
    logic [31:0] w_instr_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;
    logic [31:0] w_addr;
    logic        w_req;
    logic        w_valid;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = PCTargetE & ~32'd3;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_req       = 1'b0;
        w_addr      = r_pc;
        w_valid     = 1'b0;
        case (r_state)
            S_REQ: begin
                w_req = 1'b1;
                if (RedirectE) begin
                    w_pc_nxt    = w_target;
                    // A granted fetch of the stale PC still has to drain.
                    w_state_nxt = imem_gnt ? S_DROP : S_REQ;
                end else if (imem_gnt) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (RedirectE) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = S_HOLD;
                end
            end
            S_DROP: begin
                if (RedirectE) begin
                    w_pc_nxt = w_target;
                end
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                end
            end
            default: begin // S_HOLD
                w_valid = ~RedirectE;
                if (RedirectE) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = S_REQ;
                end else if (!StallF) begin
                    // Decode takes the held word this edge; prefetch the next one now.
                    w_req       = 1'b1;
                    w_addr      = w_pc_plus4;
                    w_pc_nxt    = w_pc_plus4;
                    w_state_nxt = imem_gnt ? S_WAIT : S_REQ;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC & ~32'd3;
            r_instr <= NOP_INSTR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
        end
    end

    assign imem_req  = w_req & ~reset;
    assign imem_addr = w_addr & ~32'd3;
    assign ValidF    = w_valid & ~reset;
    assign InstrF    = ValidF ? r_instr : NOP_INSTR;
    assign PCF       = r_pc;
    assign PCPlus4F  = w_pc_plus4;

endmodule
`default_nettype wire
